// File: rtl/adxl355_sync_ctrl.sv
// PPS-disciplined increment trim for the ADXL355 SYNC phase-accumulator generator.
// Optional PPS phase alignment of the generator is built only when ADXL355_SYNC_PHASE_EN is defined.
module adxl355_sync_ctrl #(
    parameter int unsigned clk_out0_hz  = 40000000,
    parameter int unsigned clk_sync_hz  = 1000,
    parameter int unsigned pa_sync_bits = 32,
    parameter int unsigned pps_tol_us   = 500,
    parameter int unsigned gain_shift   = 8,
    parameter int unsigned inc_range    = 4096,
    parameter int unsigned lock_tol     = 2,
    parameter int unsigned lock_n       = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_pps,
    output logic [pa_sync_bits-1:0] o_pa_inc,
    output logic                    o_pa_load,
    output logic                    o_pps_valid,
    output logic                    o_locked,
    output logic signed [31:0]      o_err
);

    // state      | meaning
    // WAIT_FIRST | no reference edge yet; timeout disabled
    // TRACK      | counting the period since the last reference edge
    // UPDATE     | one cycle applying the trim from the last valid period

    localparam int unsigned PW = pa_sync_bits;
    localparam int unsigned GW = $clog2(lock_n + 1);

    localparam longint NOM = longint'(clk_out0_hz);
    localparam longint TOL = longint'(pps_tol_us) * longint'(clk_out0_hz) / 64'sd1000000;

    localparam logic signed [31:0] NOM_S   = 32'(NOM);
    localparam logic [31:0]        MIN_P   = 32'(NOM - TOL);
    localparam logic [31:0]        MAX_P   = 32'(NOM + TOL);
    localparam logic [31:0]        TMO_CNT = 32'(NOM + TOL - 1);

    localparam logic [63:0] INC_NOM64 = (64'(clk_sync_hz) << pa_sync_bits) / 64'(clk_out0_hz);
    localparam logic [63:0] RNG64     = 64'(inc_range);

    localparam logic signed [PW:0] INC_NOM_S = $signed({1'b0, INC_NOM64[PW-1:0]});
    localparam logic signed [PW:0] INC_RNG_S = $signed({1'b0, RNG64[PW-1:0]});
    localparam logic signed [PW:0] INC_LO    = INC_NOM_S - INC_RNG_S;
    localparam logic signed [PW:0] INC_HI    = INC_NOM_S + INC_RNG_S;

    localparam logic signed [31:0] LOCK_TOL_S = 32'(lock_tol);
    localparam logic [GW-1:0]      LOCK_N_V   = GW'(lock_n);

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        TRACK      = 2'd1,
        UPDATE     = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  pps_s1_q, pps_s2_q, pps_s3_q;
    logic [31:0]           cnt_q, cnt_d;
    logic [PW-1:0]         pa_inc_q, pa_inc_d;
    logic                  pps_valid_q, pps_valid_d;
    logic                  locked_q, locked_d;
    logic signed [31:0]    err_q, err_d;
    logic [GW-1:0]         good_q, good_d;

    logic                  pps_edge;
    logic [31:0]           period;
    logic signed [31:0]    meas_err;
    logic signed [PW:0]    corr;
    logic signed [PW:0]    inc_sum;
    logic                  err_in_tol;

`ifdef ADXL355_SYNC_PHASE_EN
    logic                  pa_load_q, pa_load_d;
`endif

    assign pps_edge   = pps_s2_q & ~pps_s3_q;
    assign period     = cnt_q + 32'd1;
    assign meas_err   = $signed(period) - NOM_S;
    assign corr       = (PW + 1)'(err_q >>> gain_shift);
    assign inc_sum    = $signed({1'b0, pa_inc_q}) - corr;
    assign err_in_tol = (err_q <= LOCK_TOL_S) && (err_q >= -LOCK_TOL_S);

    always_comb begin
        state_d     = state_q;
        cnt_d       = pps_edge ? 32'd0 : cnt_q + 32'd1;
        pa_inc_d    = pa_inc_q;
        pps_valid_d = pps_valid_q;
        locked_d    = locked_q;
        err_d       = err_q;
        good_d      = good_q;
`ifdef ADXL355_SYNC_PHASE_EN
        pa_load_d   = 1'b0;
`endif
        case (state_q)
            WAIT_FIRST: begin
                if (pps_edge) begin
                    state_d = TRACK;
`ifdef ADXL355_SYNC_PHASE_EN
                    pa_load_d = 1'b1;
`endif
                end
            end
            TRACK: begin
                if (pps_edge) begin
                    err_d = meas_err;
                    if (period >= MIN_P && period <= MAX_P) begin
                        pps_valid_d = 1'b1;
                        state_d     = UPDATE;
`ifdef ADXL355_SYNC_PHASE_EN
                        pa_load_d   = 1'b1;
`endif
                    end else begin
                        // Out-of-window edge is kept as the new reference.
                        pps_valid_d = 1'b0;
                        locked_d    = 1'b0;
                        good_d      = '0;
                    end
                end else if (cnt_q == TMO_CNT) begin
                    cnt_d       = 32'd0;
                    pps_valid_d = 1'b0;
                    locked_d    = 1'b0;
                    good_d      = '0;
                    state_d     = WAIT_FIRST;
                end
            end
            UPDATE: begin
                state_d = TRACK;
                if (inc_sum < INC_LO)
                    pa_inc_d = INC_LO[PW-1:0];
                else if (inc_sum > INC_HI)
                    pa_inc_d = INC_HI[PW-1:0];
                else
                    pa_inc_d = inc_sum[PW-1:0];
                if (err_in_tol)
                    good_d = (good_q == LOCK_N_V) ? good_q : good_q + GW'(1);
                else
                    good_d = '0;
                locked_d = (good_d == LOCK_N_V);
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= WAIT_FIRST;
            pps_s1_q    <= 1'b0;
            pps_s2_q    <= 1'b0;
            pps_s3_q    <= 1'b0;
            cnt_q       <= 32'd0;
            pa_inc_q    <= INC_NOM_S[PW-1:0];
            pps_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 32'sd0;
            good_q      <= '0;
`ifdef ADXL355_SYNC_PHASE_EN
            pa_load_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pps_s1_q    <= i_pps;
            pps_s2_q    <= pps_s1_q;
            pps_s3_q    <= pps_s2_q;
            cnt_q       <= cnt_d;
            pa_inc_q    <= pa_inc_d;
            pps_valid_q <= pps_valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            good_q      <= good_d;
`ifdef ADXL355_SYNC_PHASE_EN
            pa_load_q   <= pa_load_d;
`endif
        end
    end

    assign o_pa_inc    = pa_inc_q;
    assign o_pps_valid = pps_valid_q;
    assign o_locked    = locked_q;
    assign o_err       = err_q;
`ifdef ADXL355_SYNC_PHASE_EN
    assign o_pa_load   = pa_load_q;
`else
    assign o_pa_load   = 1'b0;
`endif

endmodule

// File: tb/tb_adxl355_sync_ctrl.sv
// Directed bench for adxl355_sync_ctrl with a scaled-down clock (1000 cycles per PPS second).
module tb_adxl355_sync_ctrl;

    localparam int     NOM     = 1000;
    localparam int     MIN_P   = 980;
    localparam int     MAX_P   = 1020;
    localparam longint INC_NOM = 64'd429496729;
    localparam longint INC_LO  = INC_NOM - 100;
    localparam longint INC_HI  = INC_NOM + 100;
`ifdef ADXL355_SYNC_PHASE_EN
    localparam bit     PH      = 1'b1;
`else
    localparam bit     PH      = 1'b0;
`endif

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_pps = 1'b0;
    logic [31:0]        o_pa_inc;
    logic               o_pa_load;
    logic               o_pps_valid;
    logic               o_locked;
    logic signed [31:0] o_err;

    adxl355_sync_ctrl #(
        .clk_out0_hz (1000),
        .clk_sync_hz (100),
        .pa_sync_bits(32),
        .pps_tol_us  (20000),
        .gain_shift  (0),
        .inc_range   (100),
        .lock_tol    (2),
        .lock_n      (3)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_pps      (i_pps),
        .o_pa_inc   (o_pa_inc),
        .o_pa_load  (o_pa_load),
        .o_pps_valid(o_pps_valid),
        .o_locked   (o_locked),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        longint err;
        longint inc;
        bit     valid;
        bit     locked;
        bit     load;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    string  cur_tag = "reset";
    int     edge_no = 0;

    bit     m_tracking;
    longint m_inc;
    longint m_err;
    int     m_good;
    bit     m_valid;
    bit     m_locked;

    task automatic chk(input string tag, input longint obs, input longint exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input bit ld);
        exp_t e;
        e.err    = m_err;
        e.inc    = m_inc;
        e.valid  = m_valid;
        e.locked = m_locked;
        e.load   = ld;
        sb.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (sb.size() != 0);
        if (ok) e = sb.pop_front();
        else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", cur_tag);
        end
    endtask

    task automatic model_reset();
        m_tracking = 1'b0;
        m_inc      = INC_NOM;
        m_err      = 0;
        m_good     = 0;
        m_valid    = 1'b0;
        m_locked   = 1'b0;
    endtask

    // Behaviour of one PPS edge arriving gap cycles after the previous one.
    task automatic model_edge(input int gap);
        bit ld = 1'b0;
        if (m_tracking && gap > MAX_P) begin
            m_valid    = 1'b0;
            m_locked   = 1'b0;
            m_good     = 0;
            m_tracking = 1'b0;
        end
        if (!m_tracking) begin
            m_tracking = 1'b1;
            ld         = PH;
        end else begin
            m_err = gap - NOM;
            if (gap >= MIN_P && gap <= MAX_P) begin
                m_valid = 1'b1;
                ld      = PH;
                m_inc   = m_inc - m_err;
                if (m_inc < INC_LO) m_inc = INC_LO;
                if (m_inc > INC_HI) m_inc = INC_HI;
                if (m_err <= 2 && m_err >= -2) m_good = (m_good < 3) ? m_good + 1 : 3;
                else m_good = 0;
                m_locked = (m_good == 3);
            end else begin
                m_valid  = 1'b0;
                m_locked = 1'b0;
                m_good   = 0;
            end
        end
        push_exp(ld);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".err"},    longint'(o_err),    e.err);
        chk({tag, ".inc"},    longint'(o_pa_inc), e.inc);
        chk({tag, ".valid"},  longint'(o_pps_valid), longint'(e.valid));
        chk({tag, ".locked"}, longint'(o_locked), longint'(e.locked));
    endtask

    // Rising PPS at the current negedge; 10-cycle pulse; checks the resulting outputs.
    task automatic pps_edge();
        exp_t  e;
        bit    ok;
        string tag;
        edge_no++;
        tag   = $sformatf("%s.e%0d", cur_tag, edge_no);
        i_pps = 1'b1;
        pop_exp(e, ok);
        idle(3);
        if (ok) chk({tag, ".load"}, longint'(o_pa_load), longint'(e.load));
        idle(1);
        chk({tag, ".load_end"}, longint'(o_pa_load), 0);
        idle(2);
        if (ok) check_all(tag, e);
        idle(4);
        i_pps = 1'b0;
    endtask

    task automatic first_edge(input string name);
        cur_tag = name;
        edge_no = 0;
        model_edge(0);
        pps_edge();
    endtask

    task automatic period(input int p);
        idle(p - 10);
        model_edge(p);
        pps_edge();
    endtask

    task automatic do_reset(input string name);
        exp_t e;
        bit   ok;
        i_rst = 1'b1;
        model_reset();
        push_exp(1'b0);
        @(negedge i_clk);
        pop_exp(e, ok);
        if (ok) begin
            check_all({name, ".rst"}, e);
            chk({name, ".rst.load"}, longint'(o_pa_load), longint'(e.load));
        end
        idle(2);
        i_rst = 1'b0;
        idle(1);
    endtask

    initial begin
        do_reset("t0");

        first_edge("t1_nominal");
        repeat (4) period(1000);
        chk("t1.locked_final", longint'(o_locked), 1);

        do_reset("t2");
        first_edge("t2_slow");
        repeat (4) period(1010);
        chk("t2.inc_final", longint'(o_pa_inc), INC_NOM - 40);
        chk("t2.err_final", longint'(o_err), 10);

        do_reset("t3");
        first_edge("t3_timeout");
        repeat (3) period(1000);
        period(1021);
        period(1000);

        cur_tag = "t4_short";
        period(979);
        period(1000);

        do_reset("t5");
        first_edge("t5_sat");
        repeat (10) period(1015);
        chk("t5.inc_sat", longint'(o_pa_inc), INC_NOM - 100);

        do_reset("t6");
        first_edge("t6_rst");
        repeat (3) period(1000);
        idle(500);
        do_reset("t6_mid");
        first_edge("t6_after");
        period(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
